// File: rtl/serie_a_paralelo_if.sv
// Serial-link receive bundle: serial bit in, deserialised byte and status out.
// master = stream source / observer, slave = deserialiser.
interface serie_a_paralelo_if;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_stb;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  byte_stb,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output byte_stb,
        output active
    );
endinterface

// File: rtl/serie_a_paralelo.sv
// MSB-first serial-to-byte deserialiser with comma-based byte alignment.
// Optional misalignment recovery in ACTIVE: define SP_REALIGN_EN.
module serie_a_paralelo #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic                clk_32f,
    input  logic                reset,
    serie_a_paralelo_if.slave   bus
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] shreg_q;
    logic [2:0] bit_cnt_q;
    logic [3:0] comma_cnt_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic       stb_q;
    logic       active_q;

`ifdef SP_REALIGN_EN
    logic [2:0] off_q;
    logic       off_vld_q;
    logic       rep_q;
`endif

    logic [7:0] shreg_d;
    logic [4:0] cnt_inc;
    logic       boundary;
    logic       is_comma;

    // Current 8-bit window including the bit being sampled this edge.
    assign shreg_d  = {shreg_q[6:0], bus.data_in};
    assign is_comma = (shreg_d == COMMA);
    assign boundary = (bit_cnt_q == 3'd7);
    assign cnt_inc  = {1'b0, comma_cnt_q} + 5'd1;

    // Single FSM: alignment search, lock counting, data delivery.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state_q     <= SEARCH;
            shreg_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            comma_cnt_q <= 4'd0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            stb_q       <= 1'b0;
            active_q    <= 1'b0;
`ifdef SP_REALIGN_EN
            off_q       <= 3'd0;
            off_vld_q   <= 1'b0;
            rep_q       <= 1'b0;
`endif
        end else begin
            shreg_q <= shreg_d;
            stb_q   <= 1'b0;
            unique case (state_q)
                SEARCH: begin
                    if (is_comma) begin
                        state_q     <= ALIGN;
                        bit_cnt_q   <= 3'd0;
                        comma_cnt_q <= 4'd1;
                    end
                end
                ALIGN: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (boundary) begin
                        stb_q <= 1'b1;
                        if (is_comma) begin
                            comma_cnt_q <= cnt_inc[3:0];
                            if (cnt_inc >= 5'(LOCK_COUNT)) begin
                                state_q  <= ACTIVE;
                                active_q <= 1'b1;
                            end
                        end else begin
                            state_q     <= SEARCH;
                            comma_cnt_q <= 4'd0;
                        end
                    end
                end
                ACTIVE: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (boundary) begin
                        stb_q <= 1'b1;
                        if (is_comma) begin
                            valid_q <= 1'b0;
`ifdef SP_REALIGN_EN
                            off_vld_q <= 1'b0;
                            rep_q     <= 1'b0;
`endif
                        end else begin
`ifdef SP_REALIGN_EN
                            if (rep_q) begin
                                state_q     <= SEARCH;
                                active_q    <= 1'b0;
                                valid_q     <= 1'b0;
                                comma_cnt_q <= 4'd0;
                                off_vld_q   <= 1'b0;
                                rep_q       <= 1'b0;
                            end else begin
                                data_q  <= shreg_d;
                                valid_q <= 1'b1;
                            end
`else
                            data_q  <= shreg_d;
                            valid_q <= 1'b1;
`endif
                        end
                    end
`ifdef SP_REALIGN_EN
                    else if (is_comma) begin
                        if (off_vld_q && off_q == bit_cnt_q) begin
                            rep_q <= 1'b1;
                        end else begin
                            off_q     <= bit_cnt_q;
                            off_vld_q <= 1'b1;
                            rep_q     <= 1'b0;
                        end
                    end
`endif
                end
                default: begin
                    state_q <= SEARCH;
                end
            endcase
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.byte_stb  = stb_q;
    assign bus.active    = active_q;

endmodule
